// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider.
// start/busy/done handshake, one quotient bit per clock.
module seq_divider #(
  parameter int DATA_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t        state;
  logic [DW-1:0] rem_q;
  logic [DW-1:0] quo_q;
  logic [DW-1:0] dvs_q;
  logic [CW-1:0] cnt;
  logic          zpend;

  logic [DW:0]   r_sh;
  logic [DW-1:0] q_sh;
  logic [DW+1:0] sum;
  logic          no_borrow;
  logic [DW-1:0] r_next;
  logic [DW-1:0] q_next;
  logic          unused_top;
  logic          accept;

  // Shift {R,Q} and do the trial subtract as R + ~D + 1.
  // R stays below the divisor, so its top working bit
  // only ever lives in the shifted copy r_sh.
  always_comb begin
    r_sh       = {rem_q, quo_q[DW-1]};
    q_sh       = {quo_q[DW-2:0], 1'b0};
    sum        = {1'b0, r_sh}
               + {1'b0, ~{1'b0, dvs_q}}
               + (DW+2)'(1);
    no_borrow  = sum[DW+1];
    unused_top = sum[DW];
    r_next     = no_borrow ? sum[DW-1:0]
                           : r_sh[DW-1:0];
    q_next     = {q_sh[DW-1:1], no_borrow};
  end

  // A new op is taken when idle or in the done cycle.
  assign accept = start &&
    (state == IDLE ||
     (state == FINISH && !zpend));

  // Control FSM, datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt         <= '0;
      zpend       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      quo_q <= dividend;
      dvs_q <= divisor;
      rem_q <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
      if (divisor == '0) begin
        zpend <= 1'b1;
        state <= FINISH;
      end else begin
        zpend <= 1'b0;
        state <= RUN;
      end
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
        end
        RUN: begin
          rem_q <= r_next;
          quo_q <= q_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= FINISH;
          end
        end
        FINISH: begin
          if (zpend) begin
            quotient    <= '1;
            remainder   <= quo_q;
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            zpend       <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider for the 20-bit datapath. It is the inverse-operation companion to the ripple adder.
- Each step is a trial subtraction, computed as a + ~b + 1 with a borrow-out.
- Sits beside the ALU and is driven by the control unit through a start/busy/done handshake. Results are held until the next operation.

Parameters:
DATA_WIDTH, 20, operand/quotient/remainder width; all arithmetic scales with it

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request a division; sampled only when busy=0
dividend  input  DATA_WIDTH  unsigned numerator, sampled with start
divisor  input  DATA_WIDTH  unsigned denominator, sampled with start
quotient  output  DATA_WIDTH  registered quotient result
remainder  output  DATA_WIDTH  registered remainder result
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when results become valid
div_by_zero  output  1  registered flag; high when the last operation had divisor=0

Behaviour:
- Reset
  - Asynchronous and active-low; rst_n low forces the IDLE state immediately.
  - Reset values: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
  - The internal step counter and working registers are cleared.
  - Reset mid-operation aborts the operation with no done pulse. The first start after rst_n deasserts is accepted normally.
- States: IDLE, RUN, FINISH.
- IDLE
  - On a clock edge with start=1, dividend and divisor are latched and busy rises at that same edge.
  - Same edge, divisor != 0: working remainder R (DATA_WIDTH+1 bits) = 0, working quotient Q = dividend, step count = 0, next state = RUN.
  - Same edge, divisor = 0: next state = FINISH with the zero-divide result staged (see FINISH).
- RUN: one iteration per clock, exactly DATA_WIDTH iterations.
  - Shift {R,Q} left by one bit.
  - Compute trial T = R - divisor, zero-extended to DATA_WIDTH+1 bits.
  - No borrow: R = T and Q[0] = 1. Borrow: R is kept and Q[0] = 0.
  - After iteration DATA_WIDTH, next state = FINISH.
- FINISH
  - Normal case: quotient = Q and remainder = R[DATA_WIDTH-1:0], loaded at the edge that ends the last iteration.
  - Zero-divide case: quotient = all ones, remainder = latched dividend, div_by_zero = 1.
  - The result is visible together with done=1 and busy=0 for exactly one cycle; the state then returns to IDLE.
- Latency and handshake
  - Start accepted at edge E0.
  - Nonzero divisor: busy=1 for cycles after E0 through E0+DATA_WIDTH edges; done=1 during the cycle after edge E0+DATA_WIDTH. That is 21 cycles from acceptance to done for width 20.
  - Zero divisor: done=1 during the cycle after edge E0+1.
  - start while busy=1 is ignored; operands must not be re-latched.
  - start asserted in the done cycle (busy=0) is accepted, giving back-to-back operations.
- Result outputs
  - quotient, remainder and div_by_zero change only when a result is loaded (or on reset), and are held stable otherwise.
  - div_by_zero is cleared when a nonzero-divisor result loads.
- Arithmetic: the trial subtraction is DATA_WIDTH+1 bits wide so no overflow is possible. Results satisfy dividend = quotient*divisor + remainder with remainder < divisor.

Test Plan:
- dividend=100, divisor=7, start one cycle -> busy rises next edge; done pulse one cycle, 21 cycles after start; quotient=14, remainder=2, div_by_zero=0.
- dividend=20'hFFFFF, divisor=1 -> quotient=20'hFFFFF, remainder=0. Then dividend=20'hFFFFF, divisor=20'hFFFFF -> quotient=1, remainder=0.
- dividend=3, divisor=10 -> quotient=0, remainder=3. Then dividend=5, divisor=0 -> done two cycles after start, quotient=20'hFFFFF, remainder=5, div_by_zero=1; the next 9/3 operation gives 3, 0, div_by_zero=0.
- Start 100/7, then pulse start with 50/5 at cycle 5 while busy -> ignored; result still 14, 2; exactly one done pulse.
- Start 100/7; assert start with 50/5 in the done cycle -> second op accepted; after the second done, quotient=10, remainder=0.
- Start 1000/3; drive rst_n low at cycle 8 (mid-edge, asynchronous) -> all outputs 0 immediately, no done. Release rst_n and start 1000/3 -> quotient=333, remainder=1.
